// File: rtl/sha1_arbiter.sv
// sha1_arbiter: round-robin sharing of one sha1 core between two requesters.
// It latches the granted 512-bit block, runs the core, returns the digest with a
// one-cycle ack, and then holds core_on low so the core can return to init.
// Optional watchdog: define SHA1_ARB_TIMEOUT_EN to abort RUN after TIMEOUT cycles.
module sha1_arbiter #(
  parameter logic [15:0] TIMEOUT     = 16'd1023,
  parameter int unsigned COOL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [511:0] msg0,
  input  logic [511:0] msg1,
  output logic         ack0,
  output logic         ack1,
  output logic [159:0] resp_digest,
  output logic         resp_err,
  output logic         busy,
  output logic         grant,
  output logic         core_on,
  output logic [511:0] core_message,
  input  logic [159:0] core_digest,
  input  logic         core_finish
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned COOL_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  state_t              r_state;
  logic [COOL_W-1:0]   r_cool;
  logic                w_any;
  logic                w_pick;
  logic                w_timeout;

  // Arbitration: a lone request wins; on contention the one not granted last wins
  assign w_any  = req0 | req1;
  assign w_pick = (req0 && req1) ? ~grant : req1;

`ifdef SHA1_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_cnt == (TIMEOUT - 16'd1));

  // RUN watchdog: cleared on grant, saturates instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_cnt <= '0;
    end else if (r_state == ST_RUN && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // Job sequencer: grant, run the core, return the result, then cool down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cool       <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      resp_digest  <= '0;
      resp_err     <= 1'b0;
      busy         <= 1'b0;
      grant        <= 1'b1;
      core_on      <= 1'b0;
      core_message <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            grant        <= w_pick;
            core_message <= w_pick ? msg1 : msg0;
            core_on      <= 1'b1;
            busy         <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          // finish has priority over a watchdog expiry in the same cycle
          if (core_finish) begin
            resp_digest <= core_digest;
            resp_err    <= 1'b0;
            r_state     <= ST_DONE;
          end else if (w_timeout) begin
            resp_digest <= '0;
            resp_err    <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack0    <= ~grant;
          ack1    <= grant;
          core_on <= 1'b0;
          r_cool  <= '0;
          r_state <= ST_COOL;
        end
        ST_COOL: begin
          if (r_cool == COOL_W'(COOL_CYCLES - 1)) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cool <= r_cool + COOL_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_arbiter.sv
// Bench for sha1_arbiter: a stub core computing real SHA-1 of one block,
// randomized requesters, and a job-level reference model of arbitration,
// latency, digest and cool-down behaviour.
module tb_sha1_arbiter;

  localparam int unsigned COOL = 2;
  localparam logic [15:0] TMO  = 16'd16;
  localparam logic [159:0] ABC_DIG = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [511:0] msg0, msg1;
  logic         ack0, ack1;
  logic [159:0] resp_digest;
  logic         resp_err;
  logic         busy;
  logic         grant;
  logic         core_on;
  logic [511:0] core_message;
  logic [159:0] core_digest;
  logic         core_finish;

  sha1_arbiter #(.TIMEOUT(TMO), .COOL_CYCLES(COOL)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .msg0(msg0), .msg1(msg1),
    .ack0(ack0), .ack1(ack1), .resp_digest(resp_digest), .resp_err(resp_err),
    .busy(busy), .grant(grant), .core_on(core_on), .core_message(core_message),
    .core_digest(core_digest), .core_finish(core_finish)
  );

  always #5 clk = ~clk;

  // Single-block SHA-1 compression from the standard initial hash values
  function automatic logic [159:0] sha1_blk(input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
            d + 32'h10325476, e + 32'hC3D2E1F0};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Stub core: finish after stub_lat cycles of core_on, or never when hung
  int unsigned on_cyc;
  int unsigned stub_lat = 4;
  bit          stub_hang = 1'b0;
  bit          rand_lat  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset)         on_cyc <= 0;
    else if (!core_on) on_cyc <= 0;
    else               on_cyc <= on_cyc + 1;
  end

  assign core_finish = core_on && !stub_hang && (on_cyc == stub_lat - 1);
  assign core_digest = sha1_blk(core_message);

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state, updated from a negedge observer
  bit           m_last = 1'b1;
  bit           in_job, owner, seen_job;
  bit           prev_on, prev_busy, prev_a0, prev_a1;
  bit           got [2];
  logic         r0p, r1p;
  logic [511:0] jmsg;
  logic [159:0] last_digest;
  int unsigned  cyc, g_cyc, a_cyc, low_cnt, ovl;
  int unsigned  acks [2];
  int unsigned  acks_total;
  int unsigned  grant_log [$];

  always @(negedge clk) begin
    bit e_g;
    bit e_err;
    cyc++;
    if (reset) begin
      prev_on = 0; prev_busy = 0; prev_a0 = 0; prev_a1 = 0;
      m_last = 1; in_job = 0; seen_job = 0; low_cnt = 0;
      grant_log.delete();
    end else begin
      if (ack0 && ack1) ovl++;
      if (prev_a0 || prev_a1) check("ack_width", 512'({ack1, ack0}), 512'(0));
      if (core_on && !prev_on) begin
        e_g = (r0p && r1p) ? !m_last : r1p;
        check("grant_has_req", 512'(r0p | r1p), 512'(1));
        check("grant", 512'(grant), 512'(e_g));
        m_last = e_g; owner = e_g;
        jmsg = e_g ? msg1 : msg0;
        check("core_msg", core_message, jmsg);
        check("busy_on_grant", 512'(busy), 512'(1));
        if (seen_job) check("cool_gap", 512'(low_cnt >= COOL + 1), 512'(1));
        g_cyc = cyc; in_job = 1;
        grant_log.push_back(int'(e_g));
        if (rand_lat) stub_lat = $urandom_range(12, 2);
      end
      if (core_on) low_cnt = 0; else low_cnt++;
      if (ack0 || ack1) begin
        e_err = stub_hang;
        check("ack_owner", 512'({ack1, ack0}), in_job ? (owner ? 512'(2) : 512'(1)) : 512'(0));
        check("resp_err", 512'(resp_err), 512'(e_err));
        check("digest", 512'(resp_digest), e_err ? 512'(0) : 512'(sha1_blk(jmsg)));
        check("ack_latency", 512'(cyc - g_cyc), e_err ? 512'(TMO + 1) : 512'(stub_lat + 1));
        last_digest = resp_digest;
        if (ack1) begin acks[1]++; got[1] = 1; end
        else      begin acks[0]++; got[0] = 1; end
        acks_total++;
        a_cyc = cyc; in_job = 0; seen_job = 1;
      end
      if (prev_busy && !busy) check("busy_fall", 512'(cyc - a_cyc), 512'(COOL));
      prev_on = core_on; prev_busy = busy; prev_a0 = ack0; prev_a1 = ack1;
    end
    r0p = req0; r1p = req1;
  end

  // Runs requesters until n_jobs more acks, then lets outstanding requests drain
  task automatic drive(input int unsigned n_jobs, input int unsigned pct0, input int unsigned pct1);
    int unsigned target = acks_total + n_jobs;
    int unsigned t = 0;
    while ((acks_total < target || req0 || req1) && t < 4000) begin
      @(posedge clk); #1; t++;
      if (got[0]) begin req0 = 0; got[0] = 0; end
      if (got[1]) begin req1 = 0; got[1] = 0; end
      if (acks_total < target) begin
        if (!req0 && $urandom_range(99, 0) < pct0) begin msg0 = rand512(); req0 = 1; end
        if (!req1 && $urandom_range(99, 0) < pct1) begin msg1 = rand512(); req1 = 1; end
      end
    end
    check("drive_budget", 512'(acks_total >= target), 512'(1));
  endtask

  task automatic wait_on(input string tag);
    int unsigned t = 0;
    while (!core_on && t < 50) begin @(negedge clk); t++; end
    check(tag, 512'(core_on), 512'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1;
    repeat (2) @(posedge clk);
    #1; reset = 0;
  endtask

  initial begin
    int unsigned a_before;
    int unsigned exp_order [4] = '{0, 1, 0, 1};
    logic [511:0] abc;
    reset = 1; req0 = 0; req1 = 0; msg0 = '0; msg1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", 512'(ack0), 512'(0));
    check("rst_ack1", 512'(ack1), 512'(0));
    check("rst_digest", 512'(resp_digest), 512'(0));
    check("rst_err", 512'(resp_err), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_grant", 512'(grant), 512'(1));
    check("rst_core_on", 512'(core_on), 512'(0));
    check("rst_core_msg", core_message, 512'(0));
    reset = 0;

    // Padded "abc" block on requester 0
    abc = {32'h61626380, 416'h0, 64'h18};
    msg0 = abc; req0 = 1;
    a_before = acks[1];
    drive(1, 0, 0);
    check("abc_digest", 512'(last_digest), 512'(ABC_DIG));
    check("abc_no_ack1", 512'(acks[1] - a_before), 512'(0));

    // Both requesting from reset: strict alternation starting with req0
    @(posedge clk); #1; reset = 1;
    msg0 = rand512(); msg1 = rand512(); req0 = 1; req1 = 1;
    repeat (2) @(posedge clk);
    #1; reset = 0;
    drive(4, 100, 100);
    check("order_len", 512'(grant_log.size() >= 4), 512'(1));
    if (grant_log.size() >= 4)
      for (int i = 0; i < 4; i++) check("order", 512'(grant_log[i]), 512'(exp_order[i]));

    // Randomized traffic with random core latency
    rand_lat = 1;
    drive(30, 40, 40);
    rand_lat = 0;

    // Finish lands on the same cycle the watchdog would fire: finish wins
    stub_lat = TMO;
    msg0 = rand512(); req0 = 1;
    drive(1, 0, 0);

`ifdef SHA1_ARB_TIMEOUT_EN
    // Hung core: error response, then normal service resumes
    stub_hang = 1;
    msg0 = rand512(); req0 = 1;
    drive(1, 0, 0);
    check("hang_err", 512'(resp_err), 512'(1));
    stub_hang = 0;
    stub_lat = 5;
    msg1 = rand512(); req1 = 1;
    drive(1, 0, 0);
`endif

    // Requester 1 withdraws after grant; its ack still arrives once
    stub_lat = 6; got[1] = 0;
    msg1 = rand512(); req1 = 1;
    wait_on("drop_grant");
    @(posedge clk); #1; req1 = 0;
    a_before = acks[1];
    repeat (15) @(posedge clk);
    #1;
    check("drop_ack_once", 512'(acks[1] - a_before), 512'(1));
    got[1] = 0;

    // Asynchronous reset in the middle of RUN, pending req1 re-served afterwards
    stub_lat = 10;
    msg1 = rand512(); req1 = 1;
    wait_on("rst_run_grant");
    @(posedge clk); #2; reset = 1; #1;
    check("arst_core_on", 512'(core_on), 512'(0));
    check("arst_busy", 512'(busy), 512'(0));
    check("arst_grant", 512'(grant), 512'(1));
    check("arst_acks", 512'({ack1, ack0}), 512'(0));
    check("arst_core_msg", core_message, 512'(0));
    a_before = acks[1];
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1; reset = 0;
    check("arst_no_ack", 512'(acks[1] - a_before), 512'(0));
    drive(1, 0, 0);
    check("arst_reserve", 512'(acks[1] - a_before), 512'(1));
    check("arst_regrant", 512'(grant_log.size() > 0 ? grant_log[0] : 2), 512'(1));

    check("ack_overlap", 512'(ovl), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
